// File: rtl/fc_dllp_scheduler.sv
// Flow-control DLLP scheduler: runs the InitFC1/InitFC2 handshake for P/NP/Cpl,
//   then issues UpdateFC DLLPs on freed-credit pulses or periodic refresh.
// Latency: one cycle from request decision to dllp_valid_o; one transfer/cycle max.
// Backpressure: valid/ready; the payload is frozen while stalled, link_up_i=0 aborts.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   link_up_i                  DL link up; low forces IDLE
//   rx_fc1_done_i/rx_fc2_done_i remote InitFC progress (levels)
//   *_credit_i                 current credits from the RX allocator
//   upd_req_i                  freed-credit pulses {Cpl, NP, P}
//   dllp_valid_o/dllp_ready_i  DLLP request handshake
//   dllp_kind_o/type_o/hdr_o/data_o  DLLP request payload
//   fc_init_done_o, state_o    status
module fc_dllp_scheduler #(
  parameter int unsigned UPDATE_PERIOD = 1024,
  parameter int unsigned INIT_GAP      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_up_i,
  input  logic        rx_fc1_done_i,
  input  logic        rx_fc2_done_i,
  input  logic [7:0]  ph_credit_i,
  input  logic [11:0] pd_credit_i,
  input  logic [7:0]  nph_credit_i,
  input  logic [11:0] npd_credit_i,
  input  logic [7:0]  cplh_credit_i,
  input  logic [11:0] cpld_credit_i,
  input  logic [2:0]  upd_req_i,
  output logic        dllp_valid_o,
  input  logic        dllp_ready_i,
  output logic [1:0]  dllp_kind_o,
  output logic [1:0]  dllp_type_o,
  output logic [7:0]  dllp_hdr_o,
  output logic [11:0] dllp_data_o,
  output logic        fc_init_done_o,
  output logic [1:0]  state_o
);

  localparam logic [1:0] TY_P    = 2'b00;
  localparam logic [1:0] TY_NP   = 2'b01;
  localparam logic [1:0] TY_CPL  = 2'b10;
  localparam logic [1:0] K_INIT1 = 2'b00;
  localparam logic [1:0] K_INIT2 = 2'b01;
  localparam logic [1:0] K_UPD   = 2'b10;

  localparam int unsigned TW = $clog2(UPDATE_PERIOD);
  localparam int unsigned GW = (INIT_GAP > 1) ? $clog2(INIT_GAP) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(UPDATE_PERIOD - 1);
  // Gap counter counts down to zero; the group restarts on the edge after it
  // reaches zero, giving exactly INIT_GAP idle cycles.
  localparam logic [GW-1:0] GAP_RELOAD   = GW'(INIT_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_INIT1  = 2'b01,
    ST_INIT2  = 2'b10,
    ST_ACTIVE = 2'b11
  } state_e;

  function automatic logic [1:0] nxt(input logic [1:0] t);
    case (t)
      TY_P:    nxt = TY_NP;
      TY_NP:   nxt = TY_CPL;
      default: nxt = TY_P;
    endcase
  endfunction

  function automatic logic [2:0] oh(input logic [1:0] t);
    oh = 3'b001 << t;
  endfunction

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [1:0]    kind_q, kind_d;
  logic [1:0]    type_q, type_d;
  logic [7:0]    hdr_q, hdr_d;
  logic [11:0]   data_q, data_d;
  logic [2:0]    pending_q, pending_d;
  logic [1:0]    rr_q, rr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;

  logic       xfer;
  logic       issue;
  logic [1:0] issue_type;
  logic [2:0] set_m, clr_m, avail;
  logic [1:0] ptr0, ptr1, ptr2;
  logic       done_sel;

  assign xfer = valid_q & dllp_ready_i;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    kind_d     = kind_q;
    type_d     = type_q;
    hdr_d      = hdr_q;
    data_d     = data_q;
    pending_d  = pending_q;
    rr_d       = rr_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    issue      = 1'b0;
    issue_type = TY_P;
    set_m      = 3'b000;
    clr_m      = 3'b000;
    avail      = 3'b000;
    ptr0       = rr_q;
    ptr1       = nxt(rr_q);
    ptr2       = nxt(nxt(rr_q));
    done_sel   = (state_q == ST_INIT1) ? rx_fc1_done_i : rx_fc2_done_i;

    if (!link_up_i) begin
      state_d   = ST_IDLE;
      valid_d   = 1'b0;
      pending_d = 3'b000;
      timer_d   = TIMER_RELOAD;
      rr_d      = TY_P;
      gap_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_INIT1;
          gap_d   = '0;
        end
        ST_INIT1, ST_INIT2: begin
          if (xfer) begin
            if (type_q == TY_CPL) begin
              // Group complete: the done level is only looked at here, so a
              // mid-group rise never truncates the group.
              valid_d = 1'b0;
              if (done_sel) begin
                state_d = (state_q == ST_INIT1) ? ST_INIT2 : ST_ACTIVE;
              end else begin
                gap_d = GAP_RELOAD;
              end
            end else begin
              issue      = 1'b1;
              issue_type = nxt(type_q);
            end
          end else if (!valid_q) begin
            if (gap_q != '0) begin
              gap_d = gap_q - GW'(1);
            end else begin
              issue      = 1'b1;
              issue_type = TY_P;
            end
          end
        end
        ST_ACTIVE: begin
          if (timer_q == '0) begin
            set_m   = 3'b111;
            timer_d = TIMER_RELOAD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
          set_m = set_m | upd_req_i;
          if (xfer) begin
            clr_m   = oh(type_q);
            valid_d = 1'b0;
            rr_d    = nxt(type_q);
            ptr0    = nxt(type_q);
          end
          ptr1  = nxt(ptr0);
          ptr2  = nxt(ptr1);
          avail = pending_q & ~clr_m;
          // Set is OR-ed after the clear so a coincident pulse keeps the bit.
          pending_d = avail | set_m;
          // Grant from registered pending only; a completing transfer frees
          // the single request slot in the same cycle.
          if (!valid_q || xfer) begin
            if (|(avail & oh(ptr0))) begin
              issue = 1'b1; issue_type = ptr0;
            end else if (|(avail & oh(ptr1))) begin
              issue = 1'b1; issue_type = ptr1;
            end else if (|(avail & oh(ptr2))) begin
              issue = 1'b1; issue_type = ptr2;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (issue) begin
      valid_d = 1'b1;
      type_d  = issue_type;
      case (state_q)
        ST_INIT1: kind_d = K_INIT1;
        ST_INIT2: kind_d = K_INIT2;
        default:  kind_d = K_UPD;
      endcase
      // Payload is captured only here, never while a request is stalled.
      case (issue_type)
        TY_NP: begin
          hdr_d  = nph_credit_i;
          data_d = npd_credit_i;
        end
        TY_CPL: begin
          hdr_d  = cplh_credit_i;
          data_d = cpld_credit_i;
        end
        default: begin
          hdr_d  = ph_credit_i;
          data_d = pd_credit_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      kind_q    <= 2'b00;
      type_q    <= 2'b00;
      hdr_q     <= 8'h00;
      data_q    <= 12'h000;
      pending_q <= 3'b000;
      rr_q      <= TY_P;
      timer_q   <= TIMER_RELOAD;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      kind_q    <= kind_d;
      type_q    <= type_d;
      hdr_q     <= hdr_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
    end
  end

  assign dllp_valid_o   = valid_q;
  assign dllp_kind_o    = kind_q;
  assign dllp_type_o    = type_q;
  assign dllp_hdr_o     = hdr_q;
  assign dllp_data_o    = data_q;
  assign fc_init_done_o = (state_q == ST_ACTIVE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_fc_dllp_scheduler.sv
module tb_fc_dllp_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_up, fc1_done, fc2_done, ready;
  logic [7:0]  ph, nph, cplh;
  logic [11:0] pd, npd, cpld;
  logic [2:0]  upd_req;

  logic        valid, init_done;
  logic [1:0]  kind, typ, state;
  logic [7:0]  hdr;
  logic [11:0] data;

  logic        valid8, init_done8;
  logic [1:0]  kind8, typ8, state8;
  logic [7:0]  hdr8;
  logic [11:0] data8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_dllp_scheduler dut (
    .clk(clk), .rst_n(rst_n), .link_up_i(link_up),
    .rx_fc1_done_i(fc1_done), .rx_fc2_done_i(fc2_done),
    .ph_credit_i(ph), .pd_credit_i(pd), .nph_credit_i(nph), .npd_credit_i(npd),
    .cplh_credit_i(cplh), .cpld_credit_i(cpld), .upd_req_i(upd_req),
    .dllp_valid_o(valid), .dllp_ready_i(ready), .dllp_kind_o(kind),
    .dllp_type_o(typ), .dllp_hdr_o(hdr), .dllp_data_o(data),
    .fc_init_done_o(init_done), .state_o(state)
  );

  fc_dllp_scheduler #(.UPDATE_PERIOD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .link_up_i(link_up),
    .rx_fc1_done_i(fc1_done), .rx_fc2_done_i(fc2_done),
    .ph_credit_i(ph), .pd_credit_i(pd), .nph_credit_i(nph), .npd_credit_i(npd),
    .cplh_credit_i(cplh), .cpld_credit_i(cpld), .upd_req_i(upd_req),
    .dllp_valid_o(valid8), .dllp_ready_i(ready), .dllp_kind_o(kind8),
    .dllp_type_o(typ8), .dllp_hdr_o(hdr8), .dllp_data_o(data8),
    .fc_init_done_o(init_done8), .state_o(state8)
  );

  typedef struct {
    int          n;
    logic        link, fc1, fc2, rdy;
    logic [2:0]  upd;
    logic [7:0]  ph;
    logic [11:0] pd;
    logic        ev;
    logic [1:0]  ek, et;
    logic [7:0]  eh;
    logic [11:0] ed;
    logic [1:0]  es;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic link, input logic fc1,
                              input logic fc2, input logic rdy, input logic [2:0] upd,
                              input logic [7:0] vph, input logic [11:0] vpd,
                              input logic ev, input logic [1:0] ek, input logic [1:0] et,
                              input logic [7:0] eh, input logic [11:0] ed,
                              input logic [1:0] es);
    vec_t v;
    v.n = n; v.link = link; v.fc1 = fc1; v.fc2 = fc2; v.rdy = rdy; v.upd = upd;
    v.ph = vph; v.pd = vpd; v.ev = ev; v.ek = ek; v.et = et; v.eh = eh; v.ed = ed;
    v.es = es;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; link_up = 1'b0; fc1_done = 1'b0; fc2_done = 1'b0; ready = 1'b0;
    upd_req = 3'b000;
    ph = 8'd20; pd = 12'd300; nph = 8'd21; npd = 12'd310; cplh = 8'd22; cpld = 12'd320;

    // Columns: n, link, fc1, fc2, rdy, upd, ph, pd | valid, kind, type, hdr, data, state
    // InitFC1 group, 16-cycle gap, repeat
    add(1,  1,0,0,1,3'b000, 20,300, 0,0,0, 0,  0, 1);
    add(1,  1,0,0,1,3'b000, 20,300, 1,0,0,20,300, 1);
    add(1,  1,0,0,1,3'b000, 20,300, 1,0,1,21,310, 1);
    add(1,  1,0,0,1,3'b000, 20,300, 1,0,2,22,320, 1);
    add(1,  1,0,0,1,3'b000, 20,300, 0,0,0, 0,  0, 1);
    add(15, 1,0,0,1,3'b000, 20,300, 0,0,0, 0,  0, 1);
    // rx_fc2_done high in INIT1 must be ignored; rx_fc1_done rises during NP
    add(1,  1,0,1,1,3'b000, 20,300, 1,0,0,20,300, 1);
    add(1,  1,0,1,1,3'b000, 20,300, 1,0,1,21,310, 1);
    add(1,  1,1,1,1,3'b000, 20,300, 1,0,2,22,320, 1);
    add(1,  1,1,1,1,3'b000, 20,300, 0,0,0, 0,  0, 2);
    // InitFC2 group; upd_req ignored outside ACTIVE
    add(1,  1,1,1,1,3'b111, 20,300, 1,1,0,20,300, 2);
    add(1,  1,1,1,1,3'b111, 20,300, 1,1,1,21,310, 2);
    add(1,  1,1,1,1,3'b000, 20,300, 1,1,2,22,320, 2);
    add(1,  1,1,1,1,3'b000, 20,300, 0,0,0, 0,  0, 3);
    add(3,  1,1,1,1,3'b000, 20,300, 0,0,0, 0,  0, 3);
    // ACTIVE: stalled P UpdateFC holds its payload, then Cpl follows
    add(1,  1,1,1,0,3'b101,  5, 50, 0,0,0, 0,  0, 3);
    add(1,  1,1,1,0,3'b000,  5, 50, 1,2,0, 5, 50, 3);
    add(2,  1,1,1,0,3'b000,  9, 50, 1,2,0, 5, 50, 3);
    add(1,  1,1,1,1,3'b000,  9, 50, 1,2,2,22,320, 3);
    add(1,  1,1,1,1,3'b000,  9, 50, 0,0,0, 0,  0, 3);
    // move rr pointer to NP
    add(1,  1,1,1,1,3'b001,  9, 50, 0,0,0, 0,  0, 3);
    add(1,  1,1,1,0,3'b000,  9, 50, 1,2,0, 9, 50, 3);
    add(1,  1,1,1,1,3'b000,  9, 50, 0,0,0, 0,  0, 3);
    // all three from rr=NP; repeat NP pulse while stalled and on its transfer
    add(1,  1,1,1,0,3'b111,  9, 50, 0,0,0, 0,  0, 3);
    add(1,  1,1,1,0,3'b000,  9, 50, 1,2,1,21,310, 3);
    add(1,  1,1,1,0,3'b010,  9, 50, 1,2,1,21,310, 3);
    add(1,  1,1,1,1,3'b010,  9, 50, 1,2,2,22,320, 3);
    add(1,  1,1,1,1,3'b000,  9, 50, 1,2,0, 9, 50, 3);
    add(1,  1,1,1,1,3'b000,  9, 50, 1,2,1,21,310, 3);
    add(3,  1,1,1,1,3'b000,  9, 50, 0,0,0, 0,  0, 3);
    // link drop in ACTIVE with pending work discards it
    add(1,  1,1,1,0,3'b110,  9, 50, 0,0,0, 0,  0, 3);
    add(1,  0,1,1,0,3'b000,  9, 50, 0,0,0, 0,  0, 0);
    // relink, reach INIT2, stall, drop link, relink
    add(1,  1,1,0,0,3'b000,  9, 50, 0,0,0, 0,  0, 1);
    add(1,  1,1,0,0,3'b000,  9, 50, 1,0,0, 9, 50, 1);
    add(1,  1,1,0,1,3'b000,  9, 50, 1,0,1,21,310, 1);
    add(1,  1,1,0,1,3'b000,  9, 50, 1,0,2,22,320, 1);
    add(1,  1,1,0,1,3'b000,  9, 50, 0,0,0, 0,  0, 2);
    add(1,  1,1,0,0,3'b000,  9, 50, 1,1,0, 9, 50, 2);
    add(1,  1,1,0,0,3'b000,  9, 50, 1,1,0, 9, 50, 2);
    add(1,  0,1,0,0,3'b000,  9, 50, 0,0,0, 0,  0, 0);
    add(1,  1,1,0,0,3'b000,  9, 50, 0,0,0, 0,  0, 1);
    add(1,  1,1,0,0,3'b000,  9, 50, 1,0,0, 9, 50, 1);

    repeat (2) @(negedge clk);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset state", 32'(state), 32'd0);
    chk("reset init_done", 32'(init_done), 32'd0);
    chk("reset kind/type", 32'({kind, typ}), 32'd0);
    chk("reset hdr/data", 32'({hdr, data}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].n; r++) begin
        link_up = vecs[i].link; fc1_done = vecs[i].fc1; fc2_done = vecs[i].fc2;
        ready = vecs[i].rdy; upd_req = vecs[i].upd; ph = vecs[i].ph; pd = vecs[i].pd;
        tick();
        upd_req = 3'b000;
        chk($sformatf("row%0d.%0d valid", i, r), 32'(valid), 32'(vecs[i].ev));
        chk($sformatf("row%0d.%0d state", i, r), 32'(state), 32'(vecs[i].es));
        chk($sformatf("row%0d.%0d init_done", i, r), 32'(init_done),
            32'(vecs[i].es == 2'b11));
        if (vecs[i].ev) begin
          chk($sformatf("row%0d.%0d kind", i, r), 32'(kind), 32'(vecs[i].ek));
          chk($sformatf("row%0d.%0d type", i, r), 32'(typ), 32'(vecs[i].et));
          chk($sformatf("row%0d.%0d hdr", i, r), 32'(hdr), 32'(vecs[i].eh));
          chk($sformatf("row%0d.%0d data", i, r), 32'(data), 32'(vecs[i].ed));
        end
      end
    end

    // Periodic refresh: dut8 refreshes every 8 cycles, the default-period
    // instance must stay quiet over the same window.
    link_up = 1'b1; fc1_done = 1'b1; fc2_done = 1'b1; ready = 1'b1; upd_req = 3'b000;
    begin
      int guard;
      guard = 0;
      while (state8 != 2'b11 && guard < 100) begin
        tick();
        guard++;
      end
      chk("timer reach ACTIVE", 32'(state8), 32'd3);
      chk("timer entry valid", 32'(valid8), 32'd0);
      if (state8 == 2'b11) begin
        for (int k = 1; k <= 40; k++) begin
          logic       ev;
          logic [1:0] et;
          tick();
          ev = (k >= 9) && (((k - 9) % 8) < 3);
          et = (k >= 9) ? 2'((k - 9) % 8) : 2'd0;
          chk($sformatf("timer k%0d valid", k), 32'(valid8), 32'(ev));
          if (ev) begin
            chk($sformatf("timer k%0d type", k), 32'(typ8), 32'(et));
            chk($sformatf("timer k%0d kind", k), 32'(kind8), 32'd2);
          end
          chk($sformatf("timer k%0d long-period valid", k), 32'(valid), 32'd0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
